// File: rtl/decrypt_scheduler.sv
// Arbitrates NREQ requesters onto one shared decryption core and returns tagged plaintext.
// Define DEC_SCHED_RR_EN for round-robin arbitration; otherwise the lowest pending index wins.
module decrypt_scheduler #(
    parameter int N        = 8,
    parameter int NREQ     = 4,
    parameter int CORE_LAT = 1,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_key,
    input  logic [NREQ*N-1:0] req_e_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      core_key,
    output logic [N-1:0]      core_e_data,
    input  logic [N-1:0]      core_data,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [N-1:0]      resp_data,
    output logic              busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] LAT = 4'(CORE_LAT);

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [IDW-1:0] id_q;
    logic [N-1:0]   key_q;
    logic [N-1:0]   edata_q;
    logic [N-1:0]   resp_data_q;
    logic [IDW-1:0] resp_id_q;
    logic           resp_valid_q;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;

`ifdef DEC_SCHED_RR_EN
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Search starts at the pointer and wraps, so the last winner drops to lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && grant_found) begin
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(k);
            end
        end
    end
`endif

    // Ready is gated by reset_n so nothing is offered while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset_n && state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            id_q         <= '0;
            key_q        <= '0;
            edata_q      <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        key_q   <= req_key[grant_idx*N +: N];
                        edata_q <= req_e_data[grant_idx*N +: N];
                        id_q    <= grant_idx;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == LAT) begin
                        resp_data_q  <= core_data;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_key    = key_q;
    assign core_e_data = edata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_data   = resp_data_q;
    assign busy        = (state_q == WAIT);

endmodule

// File: tb/tb_decrypt_scheduler.sv
// Directed bench for decrypt_scheduler with a register-based core stub and response scoreboard.
// Expected arbitration follows DEC_SCHED_RR_EN when it is defined for the build.
module tb_decrypt_scheduler;

    localparam int N        = 8;
    localparam int NREQ     = 4;
    localparam int CORE_LAT = 1;
    localparam int IDW      = $clog2(NREQ);

    typedef struct {
        logic [IDW-1:0] id;
        logic [N-1:0]   data;
    } resp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_key;
    logic [NREQ*N-1:0] req_e_data;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      core_key;
    logic [N-1:0]      core_e_data;
    logic [N-1:0]      core_data;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [N-1:0]      resp_data;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0]    tbKey  [NREQ];
    logic [N-1:0]    tbData [NREQ];
    logic [NREQ-1:0] tbValid;
    resp_t           sb[$];
    logic [IDW-1:0]  seenIds[$];

    bit mBusy;
    int mCnt;
    int mPtr;

    always #5 clock = ~clock;

    // Core stand-in: one register stage between the key/ciphertext and the plaintext.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) core_data <= '0;
        else          core_data <= core_e_data ^ core_key;
    end

    decrypt_scheduler #(.N(N), .NREQ(NREQ), .CORE_LAT(CORE_LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_key(req_key), .req_e_data(req_e_data),
        .req_ready(req_ready),
        .core_key(core_key), .core_e_data(core_e_data), .core_data(core_data),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy)
    );

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int pickWinner(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
`ifdef DEC_SCHED_RR_EN
            if (v[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
`else
            if (v[k]) return k;
`endif
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v);
        tbValid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_key[i*N +: N]    = tbKey[i];
            req_e_data[i*N +: N] = tbData[i];
        end
        req_valid = v;
    endtask

    // One clock: check ready before the edge, advance the model, then check the response side.
    task automatic tick();
        int              g;
        logic [NREQ-1:0] expReady;
        bit              expResp;
        resp_t           e;
        #1;
        g        = mBusy ? -1 : pickWinner(tbValid);
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        @(posedge clock);
        expResp = 1'b0;
        if (mBusy) begin
            if (mCnt == CORE_LAT) begin
                mBusy   = 1'b0;
                expResp = 1'b1;
            end else begin
                mCnt++;
            end
        end else if (g >= 0) begin
            sb.push_back('{id: IDW'(g), data: tbKey[g] ^ tbData[g]});
            mBusy = 1'b1;
            mCnt  = 0;
            mPtr  = (g + 1) % NREQ;
        end
        #1;
        checkOutput("resp_valid", 32'(resp_valid), 32'(expResp));
        checkOutput("busy", 32'(busy), 32'(mBusy));
        if (resp_valid) seenIds.push_back(resp_id);
        if (expResp && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("resp_id", 32'(resp_id), 32'(e.id));
            checkOutput("resp_data", 32'(resp_data), 32'(e.data));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_core_key"}, 32'(core_key), 32'd0);
        checkOutput({tag, "_core_e_data"}, 32'(core_e_data), 32'd0);
        checkOutput({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        checkOutput({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    endtask

    task automatic doReset(input int cycles);
        reset_n = 1'b0;
        mBusy   = 1'b0;
        mCnt    = 0;
        mPtr    = 0;
        sb.delete();
        #1;
        checkResetState("rst_enter");
        repeat (cycles) @(posedge clock);
        #1;
        checkResetState("rst_hold");
        reset_n = 1'b1;
    endtask

    initial begin
        int id0Count;
        reset_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            tbKey[i]  = 8'h11 * (i + 1);
            tbData[i] = 8'hC0 + 8'(i);
        end
        applyStimulus('0);
        @(posedge clock);
        #1;
        doReset(3);

        $display("[TB] single requester 2");
        tbKey[2]  = 8'h3C;
        tbData[2] = 8'hA5;
        applyStimulus(4'b0100);
        #1;
        checkOutput("t2_ready_onehot", 32'(req_ready), 32'h4);
        tick();
        applyStimulus('0);
        tick();
        tick();
        checkOutput("t2_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("t2_resp_id", 32'(resp_id), 32'd2);
        checkOutput("t2_resp_data", 32'(resp_data), 32'h99);
        tick();
        checkOutput("t2_resp_data_hold", 32'(resp_data), 32'h99);

        $display("[TB] four requesters, eight jobs");
        doReset(1);
        seenIds.delete();
        applyStimulus(4'b1111);
        for (int t = 0; t < 60 && seenIds.size() < 8; t++) tick();
        applyStimulus('0);
        checkOutput("t3_job_count", 32'(seenIds.size()), 32'd8);
        for (int k = 0; k < seenIds.size() && k < 8; k++) begin
`ifdef DEC_SCHED_RR_EN
            checkOutput("t3_rr_order", 32'(seenIds[k]), 32'(k % NREQ));
`else
            checkOutput("t3_fixed_order", 32'(seenIds[k]), 32'd0);
`endif
        end
        tick();
        tick();

        $display("[TB] request raised during wait");
        seenIds.delete();
        applyStimulus(4'b0010);
        tick();
        applyStimulus(4'b1000);
        tick();
        tick();
        checkOutput("t4_first_id", 32'(resp_id), 32'd1);
        tick();
        checkOutput("t4_busy_after_accept", 32'(busy), 32'd1);
        applyStimulus('0);
        tick();
        tick();
        checkOutput("t4_second_id", 32'(resp_id), 32'd3);
        checkOutput("t4_second_data", 32'(resp_data), 32'(tbKey[3] ^ tbData[3]));

        $display("[TB] reset during wait");
        applyStimulus(4'b0010);
        tick();
        applyStimulus(4'b0101);
        doReset(1);
        seenIds.delete();
        tick();
        applyStimulus('0);
        tick();
        tick();
        checkOutput("t5_responses", 32'(seenIds.size()), 32'd1);
        checkOutput("t5_resp_id", 32'(resp_id), 32'd0);
        checkOutput("t5_resp_data", 32'(resp_data), 32'(tbKey[0] ^ tbData[0]));

        $display("[TB] withdrawn request");
        seenIds.delete();
        applyStimulus(4'b0010);
        tick();
        applyStimulus(4'b0001);
        tick();
        applyStimulus('0);
        tick();
        repeat (4) tick();
        id0Count = 0;
        foreach (seenIds[k]) if (seenIds[k] == '0) id0Count++;
        checkOutput("t6_id0_responses", 32'(id0Count), 32'd0);
        checkOutput("t6_total_responses", 32'(seenIds.size()), 32'd1);
        checkOutput("t6_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
